// File: rtl/ser_pkg.sv
// Shared encodings and line levels for the FIFO transmit serializer.
// FIFO_TX_SERIALIZER_PARITY_EN adds the PARITY state to the encoding.
package ser_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_CAPTURE = 3'd2,
    S_START   = 3'd3,
    S_DATA    = 3'd4,
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    S_PARITY  = 3'd5,
`endif
    S_STOP    = 3'd6
  } state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;

  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  function automatic logic stop_bits_legal(input int n);
    return (n >= STOP_BITS_MIN) && (n <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: down-counter that ticks on terminal count and reloads.
// A load restarts the period so the first bit is a full CLK_DIV long.
module bit_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - DW'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from a synchronous FIFO and sends them LSB-first with start/stop framing.
// Define FIFO_TX_SERIALIZER_PARITY_EN to append an even-parity bit after the data.
module fifo_tx_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int STOP_BITS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_fifo_rd_en,
  output logic             o_tx_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  if (!stop_bits_legal(STOP_BITS) || (CLK_DIV < 1) || (WIDTH < 1)) begin : g_bad_params
    $error("fifo_tx_serializer: illegal parameter set");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic             r_stop_cnt;
  logic             w_stop_cnt_nxt;
  logic             w_tx_nxt;
  logic             w_rd_en_nxt;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_tick;
  logic             w_launch;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
  logic             r_parity;
  logic             w_parity_nxt;
`endif

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_load),
    .o_tick(w_tick)
  );

  assign w_launch = i_enable && !i_fifo_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_launch) w_state_nxt = S_POP;
      S_POP:     w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_START;
      S_START:   if (w_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick && (r_bit_cnt == BIT_LAST)) begin
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      S_PARITY:  if (w_tick) w_state_nxt = S_STOP;
`endif
      S_STOP:    if (w_tick && (r_stop_cnt == STOP_LAST)) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the datapath; levels hold unless a bit boundary hits.
  always_comb begin
    w_tx_nxt       = o_tx_out;
    w_rd_en_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    w_parity_nxt   = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_nxt    = TX_IDLE_LEVEL;
        w_rd_en_nxt = w_launch;
      end
      S_CAPTURE: begin
        w_shift_nxt    = i_fifo_data;
        w_tx_nxt       = START_LEVEL;
        w_load         = 1'b1;
        w_bit_cnt_nxt  = '0;
        w_stop_cnt_nxt = 1'b0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        w_parity_nxt   = ^i_fifo_data;
`endif
      end
      S_START: begin
        if (w_tick) begin
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_LAST) begin
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            w_tx_nxt = r_parity;
`else
            w_tx_nxt = TX_IDLE_LEVEL;
`endif
            w_stop_cnt_nxt = 1'b0;
          end else begin
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          end
        end
      end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_tx_nxt = TX_IDLE_LEVEL;
      end
`endif
      S_STOP: begin
        w_tx_nxt = TX_IDLE_LEVEL;
        if (w_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_done_nxt = 1'b1;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_tx_nxt = TX_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx_out     <= TX_IDLE_LEVEL;
      o_fifo_rd_en <= 1'b0;
      o_done       <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      o_tx_out     <= w_tx_nxt;
      o_fifo_rd_en <= w_rd_en_nxt;
      o_done       <= w_done_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      r_parity     <= w_parity_nxt;
`endif
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Self-checking bench for fifo_tx_serializer with a behavioural FIFO and a frame-timeline model.
// Honours FIFO_TX_SERIALIZER_PARITY_EN when the design is built with it.
module tb_fifo_tx_serializer;

  localparam int WIDTH     = 8;
  localparam int CLK_DIV   = 2;
  localparam int STOP_BITS = 1;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_LEN = (1 + WIDTH + STOP_BITS + PAR_BITS) * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_rd_en;
  logic             tx_out;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] fifo_q[$];
  int               n_pops;
  logic             last_rd = 1'b0;
  // per-cycle sample {tx_out, busy, done, fifo_rd_en}
  logic [3:0]       act_l[$];
  logic [3:0]       exp_l[$];
  int               n_checks = 0;
  int               n_pass = 0;

  always #5 clk = ~clk;

  fifo_tx_serializer #(
    .WIDTH    (WIDTH),
    .CLK_DIV  (CLK_DIV),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data (fifo_data),
    .o_fifo_rd_en(fifo_rd_en),
    .o_tx_out    (tx_out),
    .o_busy      (busy),
    .o_done      (done)
  );

  // One clock: the FIFO model pops on the edge after a sampled strobe, then outputs are logged.
  task automatic tick();
    @(posedge clk);
    #1;
    if (last_rd) begin
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      n_pops++;
    end
    fifo_empty = (fifo_q.size() == 0);
    last_rd = fifo_rd_en;
    act_l.push_back({tx_out, busy, done, fifo_rd_en});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_log();
    act_l.delete();
    n_pops = 0;
  endtask

  task automatic load_fifo(input logic [WIDTH-1:0] words[$]);
    foreach (words[i]) fifo_q.push_back(words[i]);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_level(input logic lvl);
    repeat (CLK_DIV) exp_l.push_back({lvl, 1'b1, 1'b0, 1'b0});
  endtask

  // Expected timeline from the first logged edge, with enable held and every word already queued.
  task automatic build_expected(input logic [WIDTH-1:0] words[$], input int n);
    exp_l.delete();
    foreach (words[i]) begin
      if (i > 0) exp_l.push_back(4'b1010);
      exp_l.push_back(4'b1101);
      exp_l.push_back(4'b1100);
      push_level(1'b0);
      for (int b = 0; b < WIDTH; b++) push_level(words[i][b]);
      if (PAR_BITS == 1) push_level(^words[i]);
      for (int s = 0; s < STOP_BITS; s++) push_level(1'b1);
    end
    if (words.size() > 0) exp_l.push_back(4'b1010);
    while (exp_l.size() < n) exp_l.push_back(4'b1000);
  endtask

  function automatic int first_diff();
    int n;
    n = (exp_l.size() > act_l.size()) ? exp_l.size() : act_l.size();
    for (int i = 0; i < n; i++) begin
      if ((i >= exp_l.size()) || (i >= act_l.size())) return i;
      if (act_l[i] !== exp_l[i]) return i;
    end
    return -1;
  endfunction

  function automatic int count_bit(input int pos, input logic val);
    int c = 0;
    foreach (act_l[i]) if (act_l[i][pos] === val) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    run(2);
    n_checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx actual=%b required=1", tx_out); else n_pass++;
    n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en actual=%b required=0", fifo_rd_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done actual=%b required=0", done); else n_pass++;
    rst = 1'b0;
    run(2);
  endtask

  task automatic test_idle_empty();
    start_log();
    enable = 1'b1;
    run(50);
    n_checks++; if (count_bit(0, 1'b1) !== 0) $display("FAIL idle_rd_en actual=%0d required=0", count_bit(0, 1'b1)); else n_pass++;
    n_checks++; if (count_bit(3, 1'b0) !== 0) $display("FAIL idle_tx_low actual=%0d required=0", count_bit(3, 1'b0)); else n_pass++;
    n_checks++; if (count_bit(2, 1'b1) !== 0) $display("FAIL idle_busy actual=%0d required=0", count_bit(2, 1'b1)); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_single_a5();
    logic [WIDTH-1:0] w[$];
    int idx, t_start, t_done, n;
    w.push_back(8'hA5);
    n = FRAME_LEN + 8;
    start_log();
    load_fifo(w);
    enable = 1'b1;
    build_expected(w, n);
    run(n);
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL a5_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (n_pops !== 1) $display("FAIL a5_pops actual=%0d required=1", n_pops); else n_pass++;
    n_checks++; if (count_bit(1, 1'b1) !== 1) $display("FAIL a5_done_pulses actual=%0d required=1", count_bit(1, 1'b1)); else n_pass++;
    t_start = -1;
    t_done = -1;
    foreach (act_l[i]) begin
      if ((t_start < 0) && (act_l[i][3] === 1'b0)) t_start = i;
      if ((t_done < 0) && (act_l[i][1] === 1'b1)) t_done = i;
    end
    n_checks++;
    if ((t_start < 0) || (t_done - t_start != FRAME_LEN))
      $display("FAIL a5_frame_len actual=%0d required=%0d", t_done - t_start, FRAME_LEN);
    else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w[$];
    int idx, n;
    w.push_back(8'h00);
    w.push_back(8'hFF);
    n = 2 * (FRAME_LEN + 3) + 10;
    start_log();
    load_fifo(w);
    enable = 1'b1;
    build_expected(w, n);
    run(n);
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL b2b_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (n_pops !== 2) $display("FAIL b2b_pops actual=%0d required=2", n_pops); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [WIDTH-1:0] w[$];
    logic [WIDTH-1:0] sent[$];
    int idx, n;
    w.push_back(8'h3C);
    w.push_back(8'h55);
    sent.push_back(8'h3C);
    n = FRAME_LEN + 12;
    start_log();
    load_fifo(w);
    enable = 1'b1;
    build_expected(sent, n);
    run(3 + 4 * CLK_DIV);
    enable = 1'b0;
    run(n - (3 + 4 * CLK_DIV));
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL endrop_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (n_pops !== 1) $display("FAIL endrop_pops actual=%0d required=1", n_pops); else n_pass++;
    fifo_q.delete();
    run(2);
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w[$];
    logic [WIDTH-1:0] rest[$];
    int idx, n;
    w.push_back(8'h69);
    w.push_back(8'hC3);
    rest.push_back(8'hC3);
    start_log();
    load_fifo(w);
    enable = 1'b1;
    run(3 + 5 * CLK_DIV);
    rst = 1'b1;
    tick();
    n_checks++; if (tx_out !== 1'b1) $display("FAIL rstmid_tx actual=%b required=1", tx_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy actual=%b required=0", busy); else n_pass++;
    n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rstmid_rd_en actual=%b required=0", fifo_rd_en); else n_pass++;
    rst = 1'b0;
    n = FRAME_LEN + 8;
    start_log();
    build_expected(rest, n);
    run(n);
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL rstmid_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (n_pops !== 1) $display("FAIL rstmid_pops actual=%0d required=1", n_pops); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w[$];
    int idx, n, nw;
    nw = $urandom_range(3, 6);
    for (int i = 0; i < nw; i++) w.push_back(WIDTH'($urandom));
    n = nw * (FRAME_LEN + 3) + 10;
    start_log();
    load_fifo(w);
    enable = 1'b1;
    build_expected(w, n);
    run(n);
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL rand_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (n_pops !== nw) $display("FAIL rand_pops actual=%0d required=%0d", n_pops, nw); else n_pass++;
    enable = 1'b0;
  endtask

`ifdef FIFO_TX_SERIALIZER_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] w[$];
    int idx, n, p0, p1;
    w.push_back(8'hA5);
    w.push_back(8'h07);
    n = 2 * (FRAME_LEN + 3) + 10;
    p0 = 2 + (1 + WIDTH) * CLK_DIV;
    p1 = p0 + FRAME_LEN + 3;
    start_log();
    load_fifo(w);
    enable = 1'b1;
    build_expected(w, n);
    run(n);
    idx = first_diff();
    n_checks++;
    if (idx != -1) $display("FAIL par_wave cycle=%0d actual=%b required=%b", idx, act_l[idx], exp_l[idx]); else n_pass++;
    n_checks++; if (act_l[p0][3] !== 1'b0) $display("FAIL par_a5 actual=%b required=0", act_l[p0][3]); else n_pass++;
    n_checks++; if (act_l[p1][3] !== 1'b1) $display("FAIL par_07 actual=%b required=1", act_l[p1][3]); else n_pass++;
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_empty();
    test_single_a5();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
